adc_spi_slave_model: RTL and testbench
======================================

ADC_SPI_SLAVE_MODEL -- requirements
Module: adc_spi_slave_model

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of implemented 16-bit registers (addresses 0..NUM_REGS-1, 2..128).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on adc_sclk/adc_sen/adc_mosi (2..4).
REQ-003 SHALL have port gclk200m_buf, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, synchronous, active-low reset.
REQ-005 SHALL have ports adc_sclk, adc_sen, adc_mosi, input, 1 each, SPI from master; sen active-low; asynchronous to gclk200m_buf.
REQ-006 SHALL have port adc_rst, input, 1, active-high hardware reset pin from the master, synchronized internally.
REQ-007 SHALL have port adc_miso, output, 1, read data to master.
REQ-008 SHALL have port cfg_regs, output, NUM_REGS*16, flat register image; reg n at [16n+15:16n].
REQ-009 SHALL have ports wr_stb (1), wr_addr (7), wr_data (16), outputs, one-cycle commit pulse with address and data.
REQ-010 SHALL have ports frame_err (1, one-cycle pulse) and busy (1, level, high while synchronized sen low).

Function
REQ-011 SHALL pass each SPI input through SYNC_STAGES flops, then detect sclk rise/fall and sen fall/rise from the last two synchronized samples.
REQ-012 SHALL define a frame as sen low to sen high: 24 bits MSB first; bit 23 = read flag (1 = read), bits 22:16 = address, bits 15:0 = data.
REQ-013 SHALL sample mosi on each sclk rise while sen low; 5-bit bit counter cleared on sen fall, saturating at 24.
REQ-014 SHALL use FSM IDLE -> ADDR (8 bits) -> DATA (16 bits) -> DONE; sen fall from any state -> ADDR; sen rise -> IDLE.
REQ-015 Write frame (flag 0, exactly 24 bits): on sen rise SHALL update the register if address < NUM_REGS and pulse wr_stb within 3 cycles of the synchronized sen rise; wr_stb SHALL pulse even for unimplemented addresses, register file unchanged.
REQ-016 Read frame (flag 1): after 8th sclk rise SHALL latch the addressed register (0 if address >= NUM_REGS) into a 16-bit shift register; drive MSB on the next sclk fall, shift on each following fall; no register change, no wr_stb.
REQ-017 adc_miso SHALL be 0 outside read DATA phase and after the 16th data bit.
REQ-018 Frame with fewer or more than 24 sclk rises SHALL pulse frame_err on sen rise and commit nothing; extra bits beyond 24 ignored.
REQ-019 Write to address 0 with data bit 0 = 1 SHALL clear all registers to 0 on the cycle after the wr_stb cycle (self-clearing soft reset); wr_stb still reports written data.
REQ-020 Synchronized adc_rst high SHALL clear all registers, abort any frame (no wr_stb, no frame_err), force IDLE; frames ignored while high.
REQ-021 busy SHALL follow synchronized sen inverted; zero-bit frame (sen pulse, no sclk) SHALL pulse frame_err.
REQ-022 SHALL operate for sclk at most gclk200m_buf/8 (25 MHz).

Reset
REQ-023 On sys_rst_n low: cfg_regs=0, adc_miso=0, wr_stb=0, wr_addr=0, wr_data=0, frame_err=0, busy=0, FSM IDLE, counter 0, synchronizers loaded idle (sclk 0, sen 1, mosi 0).
REQ-024 sys_rst_n low mid-frame SHALL discard the frame; first recognised frame after release starts with a fresh sen fall.

Configuration
REQ-025 With macro ADC_SPI_SLV_READBACK_EN defined, read frames SHALL behave per REQ-016/017.
REQ-026 Without ADC_SPI_SLV_READBACK_EN, adc_miso SHALL be constant 0, no read shift register built; read frames SHALL complete without error, commit nothing.

Structure
REQ-027 SHALL place frame length (24), address width (7), data width (16), soft-reset address/bit and FSM state enum in shared package adc_spi_pkg.
REQ-028 SHALL implement synchronizer plus edge detect as sub-module spi_in_sync, one instance per SPI input.

Verification
REQ-029 Write 0x05=0xA5C3 at 5 MHz sclk -> one wr_stb, wr_addr=5, wr_data=0xA5C3, cfg_regs[95:80]=0xA5C3.
REQ-030 After REQ-029, read 0x85 (READBACK_EN) -> miso 0xA5C3 MSB first on 16 sclk rises; registers unchanged, no wr_stb.
REQ-031 Write 0x03 aborted after 20 bits -> frame_err pulse, no wr_stb, reg 3 unchanged; 26-bit frame -> same.
REQ-032 Write 0x00=0x0001 with regs nonzero -> wr_stb with data 0x0001, next cycle all cfg_regs=0.
REQ-033 adc_rst high at bit 12 of a write to 0x02 -> regs cleared, no wr_stb, no frame_err; next full frame accepted.
REQ-034 Write 0x7F=0x1234 with NUM_REGS=16 -> wr_stb asserted, cfg_regs unchanged; read 0xFF -> miso all zeros.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared constants, FSM state type and helpers for the ADC SPI slave model.
package adc_spi_pkg;

    localparam int FRAME_BITS   = 24;
    localparam int ADDR_W       = 7;
    localparam int DATA_W       = 16;
    localparam int HDR_BITS     = ADDR_W + 1;
    localparam int CNT_W        = 5;
    localparam int SOFT_RST_BIT = 0;

    localparam logic [ADDR_W-1:0] SOFT_RST_ADDR = '0;
    localparam logic [CNT_W-1:0]  CNT_HDR       = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0]  CNT_FULL      = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_DATA      = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } spi_state_e;

    function automatic logic is_soft_rst(input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
        return (addr == SOFT_RST_ADDR) && data[SOFT_RST_BIT];
    endfunction

endpackage

// File: rtl/adc_spi_slave_model_spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection
// taken from the last two synchronized samples.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_slave_model.sv
// Behavioural SPI register slave of an ADC: 24-bit frames, register file, soft reset.
// Define ADC_SPI_SLV_READBACK_EN to build the read-data path on adc_miso.
module adc_spi_slave_model
    import adc_spi_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     gclk200m_buf,
    input  logic                     sys_rst_n,
    input  logic                     adc_sclk,
    input  logic                     adc_sen,
    input  logic                     adc_mosi,
    input  logic                     adc_rst,
    output logic                     adc_miso,
    output logic [NUM_REGS*16-1:0]   cfg_regs,
    output logic                     wr_stb,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     frame_err,
    output logic                     busy
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sen_lvl, sen_rise, sen_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic rst_lvl, rst_rise, rst_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(gclk200m_buf), .rst_n(sys_rst_n), .din(adc_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sen (
        .clk(gclk200m_buf), .rst_n(sys_rst_n), .din(adc_sen),
        .level(sen_lvl), .rise(sen_rise), .fall(sen_fall));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(gclk200m_buf), .rst_n(sys_rst_n), .din(adc_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rst (
        .clk(gclk200m_buf), .rst_n(sys_rst_n), .din(adc_rst),
        .level(rst_lvl), .rise(rst_rise), .fall(rst_fall));

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall, rst_rise, rst_fall};

    spi_state_e                      state_q, state_d;
    logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]           frame_q, frame_d;
    logic                            extra_q, extra_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]               wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]               wr_data_q, wr_data_d;
    logic                            frame_err_q, frame_err_d;
    logic                            soft_clr_q, soft_clr_d;
    logic [2:0]                      settle_q, settle_d;
    logic                            armed_q, armed_d;
    logic                            settle_done, latch_rd;
    logic [ADDR_W-1:0]               cmt_addr;
    logic [DATA_W-1:0]               cmt_data;

    assign cmt_addr    = frame_q[DATA_W +: ADDR_W];
    assign cmt_data    = frame_q[DATA_W-1:0];
    assign settle_done = (settle_q == 3'(SYNC_STAGES + 1));

    // A sen fall only opens a frame once the synchronizers have settled after
    // reset and sen has been seen high, so a frame cut by reset is never resumed.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        extra_d     = extra_q;
        regs_d      = regs_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        soft_clr_d  = 1'b0;
        latch_rd    = 1'b0;
        settle_d    = settle_done ? settle_q : settle_q + 3'd1;
        armed_d     = armed_q | (settle_done & sen_lvl);

        if (soft_clr_q)
            regs_d = '0;

        if (rst_lvl) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            extra_d   = 1'b0;
            regs_d    = '0;
        end else if (sen_fall && armed_q) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            extra_d   = 1'b0;
            frame_d   = '0;
        end else if (sen_rise && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            if (bit_cnt_q != CNT_FULL || extra_q) begin
                frame_err_d = 1'b1;
            end else if (!frame_q[FRAME_BITS-1]) begin
                wr_stb_d   = 1'b1;
                wr_addr_d  = cmt_addr;
                wr_data_d  = cmt_data;
                soft_clr_d = is_soft_rst(cmt_addr, cmt_data);
                for (int i = 0; i < NUM_REGS; i++)
                    if (cmt_addr == ADDR_W'(i))
                        regs_d[i] = cmt_data;
            end
        end else if (sclk_rise && state_q != ST_IDLE) begin
            if (bit_cnt_q == CNT_FULL) begin
                extra_d = 1'b1;
            end else begin
                frame_d   = {frame_q[FRAME_BITS-2:0], mosi_lvl};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_d == CNT_HDR) begin
                    state_d  = ST_DATA;
                    latch_rd = frame_d[HDR_BITS-1];
                end else if (bit_cnt_d == CNT_FULL) begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge gclk200m_buf) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            extra_q     <= 1'b0;
            regs_q      <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            soft_clr_q  <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            extra_q     <= extra_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            soft_clr_q  <= soft_clr_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

`ifdef ADC_SPI_SLV_READBACK_EN
    logic [DATA_W-1:0] rd_sh_q, rd_sh_d, rd_word;
    logic [CNT_W-1:0]  rd_left_q, rd_left_d;
    logic              miso_q, miso_d;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (frame_d[ADDR_W-1:0] == ADDR_W'(i))
                rd_word = regs_q[i];
    end

    // MSB goes out on the sclk fall after the header; one bit per later fall.
    always_comb begin
        rd_sh_d   = rd_sh_q;
        rd_left_d = rd_left_q;
        miso_d    = miso_q;
        if (rst_lvl || sen_rise || sen_fall) begin
            rd_left_d = '0;
            miso_d    = 1'b0;
        end else if (latch_rd) begin
            rd_sh_d   = rd_word;
            rd_left_d = CNT_DATA;
        end else if (sclk_fall) begin
            if (rd_left_q != '0) begin
                miso_d    = rd_sh_q[DATA_W-1];
                rd_sh_d   = {rd_sh_q[DATA_W-2:0], 1'b0};
                rd_left_d = rd_left_q - CNT_W'(1);
            end else begin
                miso_d = 1'b0;
            end
        end
    end

    always_ff @(posedge gclk200m_buf) begin
        if (!sys_rst_n) begin
            rd_sh_q   <= '0;
            rd_left_q <= '0;
            miso_q    <= 1'b0;
        end else begin
            rd_sh_q   <= rd_sh_d;
            rd_left_q <= rd_left_d;
            miso_q    <= miso_d;
        end
    end

    assign adc_miso = miso_q;
`else
    logic unused_rd;
    assign unused_rd = ^{sclk_fall, latch_rd};
    assign adc_miso  = 1'b0;
`endif

    assign cfg_regs  = regs_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign busy      = ~sen_lvl;

endmodule

// File: tb/tb_adc_spi_slave_model.sv
// Scoreboard bench for adc_spi_slave_model: directed SPI frames, queued expectations.
`timescale 1ns/100ps
module tb_adc_spi_slave_model;

    localparam int NUM_REGS = 16;
    localparam int HALF     = 100;   // 5 MHz sclk

    logic gclk200m_buf = 1'b0;
    logic sys_rst_n    = 1'b0;
    logic adc_sclk     = 1'b0;
    logic adc_sen      = 1'b1;
    logic adc_mosi     = 1'b0;
    logic adc_rst      = 1'b0;
    logic                   adc_miso;
    logic [NUM_REGS*16-1:0] cfg_regs;
    logic                   wr_stb;
    logic [6:0]             wr_addr;
    logic [15:0]            wr_data;
    logic                   frame_err;
    logic                   busy;

    always #2.5 gclk200m_buf = ~gclk200m_buf;

    adc_spi_slave_model #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
        .gclk200m_buf(gclk200m_buf), .sys_rst_n(sys_rst_n),
        .adc_sclk(adc_sclk), .adc_sen(adc_sen), .adc_mosi(adc_mosi),
        .adc_rst(adc_rst), .adc_miso(adc_miso), .cfg_regs(cfg_regs),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .busy(busy));

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_wr[$];
    logic        exp_err[$];
    logic [15:0] exp_rd[$];
    logic [15:0] model[NUM_REGS];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++)
            f[16*i +: 16] = model[i];
        return f;
    endfunction

    function automatic logic [15:0] rd_exp(input logic [15:0] v);
`ifdef ADC_SPI_SLV_READBACK_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    // Commit / error monitor
    always @(negedge gclk200m_buf) begin
        if (sys_rst_n) begin
            if (wr_stb) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_stb_unexpected", {255'b0, wr_stb}, 256'b0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", {249'b0, wr_addr}, {249'b0, e.addr});
                    chk("wr_data", {240'b0, wr_data}, {240'b0, e.data});
                end
            end
            if (frame_err) begin
                if (exp_err.size() == 0)
                    chk("frame_err_unexpected", {255'b0, frame_err}, 256'b0);
                else
                    chk("frame_err", {255'b0, frame_err}, {255'b0, exp_err.pop_front()});
            end
        end
    end

    // SPI-side monitor: collects mosi/miso per frame and checks read data
    initial begin
        int          nb;
        logic        rd_flag;
        logic [15:0] sw;
        logic        idle_or;
        forever begin
            @(negedge adc_sen);
            nb = 0; rd_flag = 1'b0; sw = '0; idle_or = 1'b0;
            while (adc_sen == 1'b0) begin
                @(posedge adc_sclk or posedge adc_sen);
                if (adc_sen == 1'b0) begin
                    nb++;
                    if (nb == 1) rd_flag = adc_mosi;
                    if (rd_flag && nb > 8 && nb <= 24) sw = {sw[14:0], adc_miso};
                    else idle_or = idle_or | adc_miso;
                end
            end
            if (nb > 0)
                chk("miso_quiet", {255'b0, idle_or}, 256'b0);
            if (nb == 24 && rd_flag) begin
                if (exp_rd.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd_unexpected: got %h expected none", sw);
                end else begin
                    chk("rd_data", {240'b0, sw}, {240'b0, exp_rd.pop_front()});
                end
            end
        end
    end

    task automatic spi_frame(input logic [23:0] word, input int nbits, input int rst_at);
        logic [23:0] w;
        w = word;
        adc_sen = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            adc_mosi = (i < 24) ? w[23-i] : 1'b0;
            #HALF adc_sclk = 1'b1;
            #HALF adc_sclk = 1'b0;
            if (i + 1 == rst_at) adc_rst = 1'b1;
        end
        adc_mosi = 1'b0;
        #HALF adc_sen = 1'b1;
        #(2*HALF);
        adc_rst = 1'b0;
        #(2*HALF);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 16'h0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (5) @(negedge gclk200m_buf);
        chk("rst_cfg_regs", cfg_regs, 256'b0);
        chk("rst_outputs", {249'b0, adc_miso, wr_stb, frame_err, busy, wr_addr != 0, wr_data != 0, 1'b0}, 256'b0);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge gclk200m_buf);

        // Basic write, with busy sampled mid-frame
        exp_wr.push_back(wr_t'{7'h05, 16'hA5C3});
        model[5] = 16'hA5C3;
        fork
            spi_frame(24'h05A5C3, 24, 0);
            begin #(HALF*10); chk("busy_mid", {255'b0, busy}, {255'b0, 1'b1}); end
        join
        chk("reg5", {240'b0, cfg_regs[95:80]}, {240'b0, 16'hA5C3});
        chk("busy_idle", {255'b0, busy}, 256'b0);

        // Read back reg 5
        exp_rd.push_back(rd_exp(16'hA5C3));
        spi_frame(24'h850000, 24, 0);
        chk("regs_after_read", cfg_regs, model_flat());

        // Short and long frames
        exp_err.push_back(1'b1);
        spi_frame(24'h031111, 20, 0);
        chk("regs_after_short", cfg_regs, model_flat());
        exp_err.push_back(1'b1);
        spi_frame(24'h032222, 26, 0);
        chk("regs_after_long", cfg_regs, model_flat());

        exp_wr.push_back(wr_t'{7'h07, 16'hBEEF});
        model[7] = 16'hBEEF;
        spi_frame(24'h07BEEF, 24, 0);
        chk("regs_after_w7", cfg_regs, model_flat());

        // Soft reset: all registers zero the cycle after wr_stb
        exp_wr.push_back(wr_t'{7'h00, 16'h0001});
        fork
            spi_frame(24'h000001, 24, 0);
            begin
                int seen;
                seen = 0;
                for (int c = 0; c < 3000 && seen == 0; c++) begin
                    @(negedge gclk200m_buf);
                    if (wr_stb) seen = 1;
                end
                chk("soft_rst_stb_seen", seen, 1);
                @(negedge gclk200m_buf);
                chk("soft_rst_clear", cfg_regs, 256'b0);
            end
        join
        clear_model();

        // Hardware reset pin mid-frame
        exp_wr.push_back(wr_t'{7'h04, 16'h00FF});
        model[4] = 16'h00FF;
        spi_frame(24'h0400FF, 24, 0);
        chk("regs_after_w4", cfg_regs, model_flat());
        spi_frame(24'h025555, 24, 12);
        clear_model();
        chk("regs_after_adc_rst", cfg_regs, 256'b0);
        exp_wr.push_back(wr_t'{7'h02, 16'h5555});
        model[2] = 16'h5555;
        spi_frame(24'h025555, 24, 0);
        chk("regs_after_w2", cfg_regs, model_flat());

        // Unimplemented address
        exp_wr.push_back(wr_t'{7'h7F, 16'h1234});
        spi_frame(24'h7F1234, 24, 0);
        chk("regs_after_w7f", cfg_regs, model_flat());
        exp_rd.push_back(16'h0000);
        spi_frame(24'hFF0000, 24, 0);

        // Zero-bit frame
        exp_err.push_back(1'b1);
        spi_frame(24'h000000, 0, 0);

        exp_rd.push_back(rd_exp(16'h5555));
        spi_frame(24'h820000, 24, 0);
        chk("regs_after_r2", cfg_regs, model_flat());

        // System reset mid-frame: the cut frame must not commit
        fork
            spi_frame(24'h067777, 24, 0);
            begin
                #(HALF*12);
                sys_rst_n = 1'b0;
                repeat (3) @(negedge gclk200m_buf);
                chk("sysrst_cfg", cfg_regs, 256'b0);
                chk("sysrst_outs", {253'b0, busy, adc_miso, wr_stb}, 256'b0);
                sys_rst_n = 1'b1;
            end
        join
        clear_model();
        chk("regs_after_cut", cfg_regs, 256'b0);
        exp_wr.push_back(wr_t'{7'h06, 16'h7777});
        model[6] = 16'h7777;
        spi_frame(24'h067777, 24, 0);
        chk("regs_after_w6", cfg_regs, model_flat());

        repeat (20) @(negedge gclk200m_buf);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("err_queue_drained", exp_err.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
